// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state encoding and slice sizing for the nibble-serial adder
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;
  localparam int NIBBLES_DEF = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;
endpackage

// File: rtl/nibble_serial_adder_slice.sv
// nibble_adder_slice: combinational 4-bit adder with carry in/out
module nibble_adder_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two operands one nibble per cycle through a single reused slice
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [NIBBLE_W-1:0] s_a, s_b, s_sum;
  logic s_cout;
  assign s_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign s_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  nibble_adder_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == ADD) begin
      sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = s_sum;
      carry_d = s_cout;
      idx_d   = idx_q + 1'b1;
      // final slice: carry into the MSB xor carry out gives signed overflow
      if (idx_q == LAST) begin
        state_d = DONE;
        idx_d   = '0;
        cout_d  = s_cout;
        ovf_d   = s_cout ^ a_q[W-1] ^ b_q[W-1] ^ s_sum[NIBBLE_W-1];
      end
    end else if (start) begin
      state_d = ADD;
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
      sum_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == ADD;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule
